// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the byte-lane data memory.
// Lane numbering is big-endian: lane 3 = bits[31:24] = addr+0.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_e;

  function automatic logic [3:0] base_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: base_mask = 4'b1000;
      SZ_HALF: base_mask = 4'b1100;
      SZ_WORD: base_mask = 4'b1111;
      default: base_mask = 4'b0000;
    endcase
  endfunction

  // Enables within the first addressed word; lanes past the word edge are dropped.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    lane_mask = base_mask(size) >> offset;
  endfunction

  // Enables for lanes 3..1 of the following word when an access crosses the word edge.
  function automatic logic [2:0] spill_mask(input logic [1:0] size, input logic [1:0] offset);
    spill_mask = 3'b000;
    if (size == SZ_WORD) begin
      case (offset)
        2'd1:    spill_mask = 3'b100;
        2'd2:    spill_mask = 3'b110;
        2'd3:    spill_mask = 3'b111;
        default: spill_mask = 3'b000;
      endcase
    end else if (size == SZ_HALF && offset == 2'd3) begin
      spill_mask = 3'b100;
    end
  endfunction

  function automatic logic crosses(input logic [1:0] size, input logic [1:0] offset);
    crosses = (size == SZ_WORD && offset != 2'd0) || (size == SZ_HALF && offset == 2'd3);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: places store data on byte lanes and
// extracts/extends load data from a 7-byte window spanning two words.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [55:0] i_rbytes,
  output logic [55:0] o_wlanes,
  output logic [6:0]  o_be,
  output logic [31:0] o_rdata
);

  logic [31:0] w_wtop;
  logic [31:0] w_win;
  logic        w_sign;

  always_comb begin
    w_wtop = i_wdata;
    case (i_size)
      SZ_BYTE: w_wtop = {i_wdata[7:0], 24'h0};
      SZ_HALF: w_wtop = {i_wdata[15:0], 16'h0};
      default: w_wtop = i_wdata;
    endcase
  end

  assign o_wlanes = {w_wtop, 24'h0} >> {i_off, 3'b000};
  assign o_be     = {lane_mask(i_size, i_off), spill_mask(i_size, i_off)};

  // The window's MSB is always the first addressed byte, hence the sign source.
  always_comb begin
    w_win = i_rbytes[55:24];
    case (i_off)
      2'd0: w_win = i_rbytes[55:24];
      2'd1: w_win = i_rbytes[47:16];
      2'd2: w_win = i_rbytes[39:8];
      2'd3: w_win = i_rbytes[31:0];
      default: w_win = i_rbytes[55:24];
    endcase
  end

  assign w_sign = ~i_unsigned & w_win[31];

  always_comb begin
    o_rdata = w_win;
    case (i_size)
      SZ_BYTE: o_rdata = {{24{w_sign}}, w_win[31:24]};
      SZ_HALF: o_rdata = {{16{w_sign}}, w_win[31:16]};
      default: o_rdata = w_win;
    endcase
  end

endmodule

// File: rtl/dmem_bytelane.sv
// Word-organised data memory with big-endian byte lanes, registered response and fault
// reporting. Define DMEM_MISALIGN_SPLIT_EN to run word-crossing accesses as two beats.
// state | meaning
// IDLE  | accepting requests
// SPLIT | second beat of a word-crossing access; request port stalled
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int    DEPTH     = 1024,
  parameter int    ADDR_W    = 32,
  parameter string INIT_FILE = ""
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_resp_valid,
  output logic [31:0]       o_resp_rdata,
  output logic              o_resp_err
);

  localparam int              IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH) << 2;

  logic [31:0] r_mem [DEPTH];

  state_e      r_state, w_state_nxt;
  logic        r_resp_valid, r_resp_err;
  logic [31:0] r_resp_rdata;
  logic [31:0] r_beat0;
  logic [IDX_W-1:0] r_idx1;
  logic [3:0]  r_be1;
  logic [31:0] r_wd1;
  logic [1:0]  r_size, r_off;
  logic        r_uns, r_write;

  logic             w_accept, w_cross, w_cross_fault, w_fault, w_split, w_we0;
  logic [1:0]       w_off, w_nbytes_m1;
  logic [IDX_W-1:0] w_idx, w_idx1, w_rd_idx1;
  logic [ADDR_W:0]  w_last;
  logic [31:0]      w_word0;
  logic [23:0]      w_word1_hi;
  logic [1:0]       w_al_size, w_al_off;
  logic             w_al_uns;
  logic [55:0]      w_rbytes, w_wlanes;
  logic [6:0]       w_be7;
  logic [31:0]      w_ldata;

  assign w_off  = i_req_addr[1:0];
  assign w_idx  = i_req_addr[IDX_W+1:2];
  assign w_idx1 = w_idx + IDX_W'(1);

  always_comb begin
    w_nbytes_m1 = 2'd3;
    case (i_req_size)
      SZ_BYTE: w_nbytes_m1 = 2'd0;
      SZ_HALF: w_nbytes_m1 = 2'd1;
      default: w_nbytes_m1 = 2'd3;
    endcase
  end

  // Extra MSB keeps the last-byte address from wrapping near the top of ADDR_W.
  assign w_last  = {1'b0, i_req_addr} + {{(ADDR_W - 1){1'b0}}, w_nbytes_m1};
  assign w_cross = crosses(i_req_size, w_off);

`ifdef DMEM_MISALIGN_SPLIT_EN
  assign w_cross_fault = 1'b0;
`else
  assign w_cross_fault = w_cross;
`endif

  assign w_fault  = (i_req_size == SZ_RSVD) || (w_last >= LIMIT) || w_cross_fault;
  assign w_accept = i_req_valid && o_req_ready;
  assign w_split  = w_accept && !w_fault && w_cross;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = 1'b0;
    case (r_state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (w_split) w_state_nxt = SPLIT;
      end
      SPLIT: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_rd_idx1  = (r_state == SPLIT) ? r_idx1 : w_idx1;
  assign w_word0    = r_mem[w_idx];
  assign w_word1_hi = r_mem[w_rd_idx1][31:8];
  assign w_rbytes   = (r_state == SPLIT) ? {r_beat0, w_word1_hi} : {w_word0, w_word1_hi};
  assign w_al_size  = (r_state == SPLIT) ? r_size : i_req_size;
  assign w_al_off   = (r_state == SPLIT) ? r_off  : w_off;
  assign w_al_uns   = (r_state == SPLIT) ? r_uns  : i_req_unsigned;

  dmem_lane_align u_align (
    .i_size     (w_al_size),
    .i_off      (w_al_off),
    .i_unsigned (w_al_uns),
    .i_wdata    (i_req_wdata),
    .i_rbytes   (w_rbytes),
    .o_wlanes   (w_wlanes),
    .o_be       (w_be7),
    .o_rdata    (w_ldata)
  );

  assign w_we0 = w_accept && i_req_write && !w_fault;

  always_ff @(posedge i_clock) begin
    for (int l = 0; l < 4; l++) begin
      if (w_we0 && w_be7[l+3])
        r_mem[w_idx][8*l +: 8] <= w_wlanes[24 + 8*l +: 8];
      if (r_state == SPLIT && r_write && r_be1[l])
        r_mem[r_idx1][8*l +: 8] <= r_wd1[8*l +: 8];
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_beat0      <= 32'h0;
      r_idx1       <= '0;
      r_be1        <= 4'h0;
      r_wd1        <= 32'h0;
      r_size       <= 2'b00;
      r_off        <= 2'b00;
      r_uns        <= 1'b0;
      r_write      <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      if (r_state == SPLIT) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= 1'b0;
        r_resp_rdata <= r_write ? 32'h0 : w_ldata;
      end else if (w_accept) begin
        if (w_fault) begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b1;
          r_resp_rdata <= 32'h0;
        end else if (w_cross) begin
          r_beat0 <= w_word0;
          r_idx1  <= w_idx1;
          r_be1   <= {w_be7[2:0], 1'b0};
          r_wd1   <= {w_wlanes[23:0], 8'h00};
          r_size  <= i_req_size;
          r_off   <= w_off;
          r_uns   <= i_req_unsigned;
          r_write <= i_req_write;
        end else begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= i_req_write ? 32'h0 : w_ldata;
        end
      end
    end
  end

  assign o_resp_valid = r_resp_valid;
  assign o_resp_err   = r_resp_err;
  assign o_resp_rdata = r_resp_rdata;

endmodule
